// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB front-end arbiter.
// Holds the FSM encoding, requester index type, watchdog width and the grant rule.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef logic req_idx_t;

    localparam int unsigned TMO_W = 16;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    function automatic req_idx_t rr_pick(input logic v0, input logic v1, input req_idx_t last);
        req_idx_t pick;
        if (v0 && v1) begin
            pick = ~last;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/apb_req_capture.sv
// Single-entry request holder for one requester; flags a pulse that arrives while full.
// The req_* view bypasses the register so a fresh pulse can be granted in the same cycle.
module apb_req_capture #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              transfer,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              req_valid,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic              proto_hit
);

    logic              pend_r;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    // Capture a request when empty; the arbiter releases the slot once it is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r  <= 1'b0;
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (transfer && !pend_r) begin
            pend_r  <= 1'b1;
            write_r <= write;
            addr_r  <= addr;
            wdata_r <= wdata;
        end else if (clr) begin
            pend_r  <= 1'b0;
        end
    end

    assign req_valid = pend_r | transfer;
    assign req_write = pend_r ? write_r : write;
    assign req_addr  = pend_r ? addr_r  : addr;
    assign req_wdata = pend_r ? wdata_r : wdata;
    assign proto_hit = transfer & pend_r;

endmodule

// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin arbiter feeding the APB master's internal request port.
// One transaction in flight at a time; response is routed back to its owner.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              s0_transfer,
    input  logic              s0_write,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_wdata,
    output logic [DATA_W-1:0] s0_rdata,
    output logic              s0_ready,
    input  logic              s1_transfer,
    input  logic              s1_write,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              s1_ready,
    output logic              m_transfer,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              owner,
    output logic              timeout_err,
    output logic              proto_err
);

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    arb_state_e        state_r, state_s;
    req_idx_t          grant_s, owner_r, last_grant_r;
    logic              grant_en_s, clr0_s, clr1_s;
    logic              c0_valid_s, c0_write_s, c0_proto_s;
    logic              c1_valid_s, c1_write_s, c1_proto_s;
    logic [ADDR_W-1:0] c0_addr_s, c1_addr_s;
    logic [DATA_W-1:0] c0_wdata_s, c1_wdata_s;
    logic [TMO_W-1:0]  cnt_r, cnt_inc_s;
    logic              m_transfer_r, m_write_r, s0_ready_r, s1_ready_r;
    logic              timeout_r, proto_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r, s0_rdata_r, s1_rdata_r;

    assign clr0_s = (state_r == ISSUE) && (owner_r == 1'b0);
    assign clr1_s = (state_r == ISSUE) && (owner_r == 1'b1);

    apb_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap0 (
        .clk(PCLK), .rst(PRESET), .transfer(s0_transfer), .write(s0_write),
        .addr(s0_addr), .wdata(s0_wdata), .clr(clr0_s),
        .req_valid(c0_valid_s), .req_write(c0_write_s), .req_addr(c0_addr_s),
        .req_wdata(c0_wdata_s), .proto_hit(c0_proto_s)
    );

    apb_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap1 (
        .clk(PCLK), .rst(PRESET), .transfer(s1_transfer), .write(s1_write),
        .addr(s1_addr), .wdata(s1_wdata), .clr(clr1_s),
        .req_valid(c1_valid_s), .req_write(c1_write_s), .req_addr(c1_addr_s),
        .req_wdata(c1_wdata_s), .proto_hit(c1_proto_s)
    );

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and grant selection; m_ready outside WAIT is deliberately ignored.
    always_comb begin
        state_s    = state_r;
        grant_en_s = 1'b0;
        grant_s    = rr_pick(c0_valid_s, c1_valid_s, last_grant_r);
        case (state_r)
            IDLE: begin
                if (c0_valid_s || c1_valid_s) begin
                    grant_en_s = 1'b1;
                    state_s    = ISSUE;
                end else begin
                    state_s    = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (m_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign cnt_inc_s = cnt_r + TMO_ONE;

    // Downstream request, response routing, watchdog and sticky error flags.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_transfer_r <= 1'b0;
            m_write_r    <= 1'b0;
            m_addr_r     <= '0;
            m_wdata_r    <= '0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            s0_ready_r   <= 1'b0;
            s1_ready_r   <= 1'b0;
            s0_rdata_r   <= '0;
            s1_rdata_r   <= '0;
            cnt_r        <= '0;
            timeout_r    <= 1'b0;
            proto_r      <= 1'b0;
        end else begin
            m_transfer_r <= grant_en_s;
            s0_ready_r   <= 1'b0;
            s1_ready_r   <= 1'b0;
            proto_r      <= proto_r | c0_proto_s | c1_proto_s;
            if (grant_en_s) begin
                owner_r      <= grant_s;
                last_grant_r <= grant_s;
                m_write_r    <= grant_s ? c1_write_s : c0_write_s;
                m_addr_r     <= grant_s ? c1_addr_s  : c0_addr_s;
                m_wdata_r    <= grant_s ? c1_wdata_s : c0_wdata_s;
            end
            if (state_r == ISSUE) begin
                cnt_r <= '0;
            end else if ((state_r == WAIT) && (cnt_r != TMO_LIM)) begin
                cnt_r <= cnt_inc_s;
                if (cnt_inc_s == TMO_LIM) begin
                    timeout_r <= 1'b1;
                end
            end
            if ((state_r == WAIT) && m_ready) begin
                if (owner_r) begin
                    s1_rdata_r <= m_rdata;
                    s1_ready_r <= 1'b1;
                end else begin
                    s0_rdata_r <= m_rdata;
                    s0_ready_r <= 1'b1;
                end
            end
        end
    end

    assign m_transfer  = m_transfer_r;
    assign m_write     = m_write_r;
    assign m_addr      = m_addr_r;
    assign m_wdata     = m_wdata_r;
    assign s0_ready    = s0_ready_r;
    assign s1_ready    = s1_ready_r;
    assign s0_rdata    = s0_rdata_r;
    assign s1_rdata    = s1_rdata_r;
    assign owner       = owner_r;
    assign timeout_err = timeout_r;
    assign proto_err   = proto_r;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Self-checking bench for apb_bus_arbiter: vector table plus directed corner sequences,
// with expected issues/responses queued at drive time and checked as the DUT produces them.
module tb_apb_bus_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        s0_transfer, s0_write, s1_transfer, s1_write;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata, s0_rdata, s1_rdata;
    logic        s0_ready, s1_ready;
    logic        m_transfer, m_write, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        owner, timeout_err, proto_err;

    apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .s0_transfer(s0_transfer), .s0_write(s0_write), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rdata(s0_rdata), .s0_ready(s0_ready),
        .s1_transfer(s1_transfer), .s1_write(s1_write), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rdata(s1_rdata), .s1_ready(s1_ready),
        .m_transfer(m_transfer), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .owner(owner), .timeout_err(timeout_err), .proto_err(proto_err)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        who;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          due;
        bit          after;
    } txn_t;

    typedef struct {
        logic        who;
        logic [31:0] rdata;
        int          due;
    } rsp_t;

    typedef struct {
        logic        who;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    txn_t        exp_issue[$];
    rsp_t        exp_resp[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          outstanding = 0;
    int          last_ready_cyc = -10;
    bit          rsp_kill = 1'b0;
    logic [31:0] exp_rd0 = 32'd0;
    logic [31:0] exp_rd1 = 32'd0;
    vec_t        vecs[5];

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic drive_req(input logic who, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (who) begin
            s1_transfer = 1'b1; s1_write = wr; s1_addr = addr; s1_wdata = wdata;
        end else begin
            s0_transfer = 1'b1; s0_write = wr; s0_addr = addr; s0_wdata = wdata;
        end
    endtask

    task automatic clear_req();
        s0_transfer = 1'b0;
        s1_transfer = 1'b0;
    endtask

    task automatic push_issue(input logic who, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int lat, input int due, input bit after);
        txn_t t;
        t.who = who; t.wr = wr; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.lat = lat; t.due = due; t.after = after;
        exp_issue.push_back(t);
        outstanding++;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && outstanding != 0; i++) @(posedge PCLK);
        #1;
        check("completion_budget", outstanding, 0);
    endtask

    // Downstream responder: checks each issued request, then answers after its latency.
    initial begin : responder
        txn_t t;
        rsp_t r;
        m_ready = 1'b0;
        m_rdata = 32'd0;
        forever begin
            @(negedge PCLK);
            if (m_transfer === 1'b1) begin
                if (exp_issue.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    t = exp_issue.pop_front();
                    check("issue_owner", owner, t.who);
                    check("issue_write", m_write, t.wr);
                    check("issue_addr", m_addr, t.addr);
                    if (t.wr) check("issue_wdata", m_wdata, t.wdata);
                    if (t.after) check("issue_after_ready", cyc, last_ready_cyc + 1);
                    else check("issue_latency", cyc, t.due);
                    for (int k = 0; k < t.lat && !rsp_kill; k++) @(posedge PCLK);
                    if (!rsp_kill) begin
                        #1;
                        m_ready = 1'b1;
                        m_rdata = t.rdata;
                        r.who = t.who; r.rdata = t.rdata; r.due = cyc + 1;
                        exp_resp.push_back(r);
                        @(posedge PCLK);
                        #1;
                        m_ready = 1'b0;
                        m_rdata = 32'hDEAD_0000;
                    end
                end
            end
        end
    end

    // Response monitor: owner routing, one-cycle latency and rdata hold on the non-owner.
    initial begin : resp_mon
        rsp_t r;
        forever begin
            @(negedge PCLK);
            if (PRESET === 1'b0 && (s0_ready === 1'b1 || s1_ready === 1'b1)) begin
                if (s0_ready === 1'b1 && s1_ready === 1'b1) begin
                    check("ready_both", 1, 0);
                end else if (exp_resp.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    r = exp_resp.pop_front();
                    check("ready_owner", s1_ready, r.who);
                    check("ready_latency", cyc, r.due);
                    if (r.who) exp_rd1 = r.rdata;
                    else exp_rd0 = r.rdata;
                    check("s0_rdata", s0_rdata, exp_rd0);
                    check("s1_rdata", s1_rdata, exp_rd1);
                    outstanding--;
                    last_ready_cyc = cyc;
                end
            end
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin : main
        int c0, c1, g;
        vecs[0] = '{1'b0, 1'b0, 32'h1000_2000, 32'h0000_0000, 32'h0000_00A5, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 32'h0000_0001, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8000_0001, 1};
        vecs[3] = '{1'b0, 1'b1, 32'h1000_0020, 32'h1234_5678, 32'hCAFE_0000, 3};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 6};

        PRESET = 1'b1;
        s0_write = 1'b0; s0_addr = 32'd0; s0_wdata = 32'd0;
        s1_write = 1'b0; s1_addr = 32'd0; s1_wdata = 32'd0;
        clear_req();
        tick(2);
        check("reset_ctrl", {m_transfer, m_write, s0_ready, s1_ready, owner, timeout_err, proto_err}, 7'd0);
        check("reset_m_addr", m_addr, 32'd0);
        check("reset_rdata", {s0_rdata, s1_rdata}, 64'd0);
        PRESET = 1'b0;
        tick(2);

        // Simultaneous pulses right after reset: req0 first, req1 right after.
        drive_req(1'b0, 1'b1, 32'h1000_3000, 32'h0000_0055);
        drive_req(1'b1, 1'b0, 32'h1000_4000, 32'h0000_0000);
        push_issue(1'b0, 1'b1, 32'h1000_3000, 32'h0000_0055, 32'h0000_0003, 2, cyc + 1, 1'b0);
        push_issue(1'b1, 1'b0, 32'h1000_4000, 32'h0000_0000, 32'h0000_0004, 3, 0, 1'b1);
        tick(1);
        clear_req();
        wait_done(60);
        tick(1);

        // Uncontended vectors.
        for (int i = 0; i < 5; i++) begin
            drive_req(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            push_issue(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                       vecs[i].lat, cyc + 1, 1'b0);
            tick(1);
            clear_req();
            wait_done(60);
            tick(1);
        end
        check("no_errors_yet", {timeout_err, proto_err}, 2'b00);

        // Fairness: both re-pulse on their own ready; expect 0,1,0,1,0,1.
        drive_req(1'b0, 1'b0, 32'h2000_0000, 32'h0);
        drive_req(1'b1, 1'b1, 32'h3000_0000, 32'h5A5A_0000);
        push_issue(1'b0, 1'b0, 32'h2000_0000, 32'h0, 32'h0A00_0000, 2, cyc + 1, 1'b0);
        push_issue(1'b1, 1'b1, 32'h3000_0000, 32'h5A5A_0000, 32'h0B00_0000, 2, 0, 1'b1);
        tick(1);
        clear_req();
        c0 = 1; c1 = 1; g = 0;
        while ((c0 < 3 || c1 < 3) && g < 200) begin
            @(negedge PCLK);
            g++;
            if (s0_ready === 1'b1 && c0 < 3) begin
                drive_req(1'b0, 1'b0, 32'h2000_0000 + 32'(c0 * 4), 32'h0);
                push_issue(1'b0, 1'b0, 32'h2000_0000 + 32'(c0 * 4), 32'h0, 32'h0A00_0000 + 32'(c0), 2, 0, 1'b1);
                c0++;
                tick(1);
                clear_req();
            end else if (s1_ready === 1'b1 && c1 < 3) begin
                drive_req(1'b1, 1'b1, 32'h3000_0000 + 32'(c1 * 4), 32'h5A5A_0000 + 32'(c1));
                push_issue(1'b1, 1'b1, 32'h3000_0000 + 32'(c1 * 4), 32'h5A5A_0000 + 32'(c1),
                           32'h0B00_0000 + 32'(c1), 2, 0, 1'b1);
                c1++;
                tick(1);
                clear_req();
            end
        end
        check("fairness_repulses", {c0[3:0], c1[3:0]}, 8'h33);
        wait_done(80);
        tick(1);

        // Protocol error: req1 pulses again while its first request waits behind req0.
        drive_req(1'b0, 1'b0, 32'h1000_5000, 32'h0);
        push_issue(1'b0, 1'b0, 32'h1000_5000, 32'h0, 32'h0000_0011, 5, cyc + 1, 1'b0);
        tick(1);
        clear_req();
        drive_req(1'b1, 1'b1, 32'h1000_6000, 32'h0000_0066);
        push_issue(1'b1, 1'b1, 32'h1000_6000, 32'h0000_0066, 32'h0000_0022, 2, 0, 1'b1);
        tick(1);
        clear_req();
        check("proto_before", proto_err, 1'b0);
        tick(1);
        drive_req(1'b1, 1'b1, 32'h1000_7000, 32'h0000_0077);
        tick(1);
        clear_req();
        check("proto_set", proto_err, 1'b1);
        wait_done(60);
        tick(4);
        check("proto_sticky", proto_err, 1'b1);

        // Watchdog: response withheld for 12 cycles against a limit of 8.
        drive_req(1'b0, 1'b0, 32'h1000_8000, 32'h0);
        push_issue(1'b0, 1'b0, 32'h1000_8000, 32'h0, 32'h0000_0BAD, 12, cyc + 1, 1'b0);
        tick(1);
        clear_req();
        tick(4);
        check("timeout_early", timeout_err, 1'b0);
        tick(7);
        check("timeout_set", timeout_err, 1'b1);
        wait_done(40);
        tick(2);
        check("timeout_sticky", timeout_err, 1'b1);

        // Asynchronous reset in WAIT with req1 pending.
        drive_req(1'b0, 1'b0, 32'h1000_9000, 32'h0);
        push_issue(1'b0, 1'b0, 32'h1000_9000, 32'h0, 32'h0000_0099, 40, cyc + 1, 1'b0);
        tick(1);
        clear_req();
        tick(3);
        drive_req(1'b1, 1'b0, 32'h1000_A000, 32'h0);
        tick(1);
        clear_req();
        #2;
        PRESET = 1'b1;
        rsp_kill = 1'b1;
        #1;
        check("rst_async_ctrl", {m_transfer, m_write, s0_ready, s1_ready, owner, timeout_err, proto_err}, 7'd0);
        check("rst_async_addr", m_addr, 32'd0);
        check("rst_async_rdata", {s0_rdata, s1_rdata}, 64'd0);
        outstanding = 0;
        exp_issue.delete();
        exp_resp.delete();
        exp_rd0 = 32'd0;
        exp_rd1 = 32'd0;
        tick(2);
        PRESET = 1'b0;
        tick(2);
        rsp_kill = 1'b0;
        tick(6);
        drive_req(1'b1, 1'b1, 32'h1000_B000, 32'h0000_00BB);
        push_issue(1'b1, 1'b1, 32'h1000_B000, 32'h0000_00BB, 32'h0000_00CC, 2, cyc + 1, 1'b0);
        tick(1);
        clear_req();
        wait_done(40);
        tick(3);
        check("post_reset_owner", owner, 1'b1);
        check("leftover_issues", exp_issue.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
- Two-requester arbiter in front of the single APB master's internal request port (transfer/ready/write/addr/wdata/rdata).
- Requester 0 is the RV32I core's data bus; requester 1 is a future DMA/debug master.
- Latches one-cycle request pulses, grants round-robin, issues one transaction at a time downstream and routes the response back to the owner.
- Includes a watchdog that flags peripherals that never assert ready.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 1024, cycles in WAIT before timeout_err sets; range 2..65535

Ports:
- PCLK  input  1  clock
- PRESET  input  1  asynchronous active-high reset
- s0_transfer  input  1  req0 one-cycle request pulse
- s0_write  input  1  req0 write(1)/read(0), valid with pulse
- s0_addr  input  ADDR_W  req0 address, valid with pulse
- s0_wdata  input  DATA_W  req0 write data, valid with pulse
- s0_rdata  output  DATA_W  req0 read data, valid with s0_ready
- s0_ready  output  1  req0 completion pulse
- s1_transfer, s1_write, s1_addr, s1_wdata, s1_rdata, s1_ready  same as s0_* for req1
- m_transfer  output  1  one-cycle pulse to APB master
- m_write  output  1  to APB master
- m_addr  output  ADDR_W  to APB master
- m_wdata  output  DATA_W  to APB master
- m_rdata  input  DATA_W  from APB master, valid with m_ready
- m_ready  input  1  APB master completion pulse
- owner  output  1  requester of the current/last transaction
- timeout_err  output  1  sticky, transaction exceeded TIMEOUT_CYCLES
- proto_err  output  1  sticky, requester pulsed while its own request pending

Behaviour:
- Reset (async, PRESET=1): all outputs 0; pending flags cleared; last_grant=1, so req0 wins the first tie; state IDLE; watchdog counter 0.
- Per-requester capture register (pend, write, addr, wdata):
  - sX_transfer=1 with pend=0 latches the request and sets pend.
  - sX_transfer=1 with pend=1 is dropped; proto_err sets.
  - Capture in the same cycle the requester's sX_ready fires is legal (pend re-sets).
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If any pend (including a pend set by a transfer pulse this cycle, i.e. capture bypass), grant:
    - Only one pending: that one.
    - Both pending: the requester != last_grant.
  - Drive m_* from the granted requester's capture, set owner and last_grant, go to ISSUE.
- ISSUE:
  - m_transfer=1 for exactly this one cycle; m_write/m_addr/m_wdata stable from ISSUE until exit of WAIT.
  - Clear the owner's pend.
  - Go to WAIT.
- WAIT:
  - On m_ready: register m_rdata into s{owner}_rdata, pulse s{owner}_ready for one cycle (cycle after m_ready), go to IDLE.
  - m_ready in ISSUE or IDLE is ignored.
- Latency, uncontended: sX_transfer at cycle N -> m_transfer at N+1; m_ready at M -> sX_ready at M+1.
- Minimum repeat interval per transaction: 3 cycles + downstream latency.
- Non-owner sX_rdata holds its previous value; sX_ready is never asserted for the non-owner.
- Watchdog:
  - Counter clears on entering WAIT and increments each WAIT cycle.
  - At count == TIMEOUT_CYCLES: timeout_err sets (sticky until reset); FSM stays in WAIT.
  - Counter saturates.
- Reset mid-transaction aborts silently: no s_ready; pending requests lost.
- Writes also produce sX_ready; sX_rdata is then loaded with m_rdata as returned.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE, ISSUE, WAIT), requester-index type, TIMEOUT counter width constant.
- Sub-module apb_req_capture: one pending register with proto_err detect, instantiated twice.

Test Plan:
- Single read:
  - Stimulus: s0 pulse (addr 0x1000_2000, read); m_ready two cycles after m_transfer with m_rdata 0x0000_00A5.
  - Required: m_transfer one cycle after pulse; s0_ready one cycle after m_ready; s0_rdata=0x0000_00A5; s1_ready stays 0.
- Simultaneous pulses:
  - Stimulus: s0 (write 0x1000_3000, 0x55) and s1 (read 0x1000_4000) in the same cycle after reset.
  - Required: s0 issued first; s1 issued in the cycle after s0_ready's WAIT exits; owner 0 then 1.
- Fairness:
  - Stimulus: both requesters re-pulse immediately on each sX_ready, for 6 transactions.
  - Required: strict alternation 0,1,0,1,0,1.
- Protocol error:
  - Stimulus: s1 pulses twice while its first request waits behind s0.
  - Required: proto_err=1; only one s1 transaction issued, using the first pulse's addr/wdata.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; m_ready withheld for 12 cycles, then asserted.
  - Required: timeout_err rises on WAIT cycle 8 and stays 1; s0_ready still delivered after the late m_ready.
- Reset mid-WAIT:
  - Stimulus: PRESET asserted asynchronously during WAIT with s1 pending.
  - Required: all outputs 0 immediately; after release, no stale transaction issued; the next s1 request is granted first (last_grant=1 rule does not apply to it alone).
